cfg_frame_loader: RTL and testbench

//  Serial configuration loader sitting directly upstream of the connection box.

---
 rtl/cfg_pkg.sv | 27 ++
 rtl/cfg_shift_stage.sv | 48 ++++
 rtl/cfg_frame_loader.sv | 129 ++++++++++++
 tb/tb_cfg_frame_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared widths, field offsets and state encoding for the serial configuration loader.
package cfg_pkg;

    localparam int ROOF_W   = 25;
    localparam int SEL_W    = 10;
    localparam int FRAME_W  = ROOF_W + SEL_W + 1;
    localparam int CNT_W    = 6;

    localparam int ROOF_LSB = 0;
    localparam int SEL_LSB  = 25;
    localparam int PAR_BIT  = 35;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } cfg_state_e;

    // One step of a running even-parity accumulator.
    function automatic logic par_fold(input logic acc, input logic b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/cfg_shift_stage.sv
// Staging register, saturating bit counter and running parity for one serial frame.
module cfg_shift_stage
    import cfg_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               accept,
    input  logic               bit_in,
    output logic [FRAME_W-1:0] staging,
    output logic               last,
    output logic               par_ok
);

    logic [FRAME_W-1:0] staging_r;
    logic [CNT_W-1:0]   count_r;
    logic               par_r;

    // Capture accepted bits LSB first; the counter parks on the parity slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging_r <= '0;
            count_r   <= '0;
            par_r     <= 1'b0;
        end else if (clear) begin
            staging_r <= '0;
            count_r   <= '0;
            par_r     <= 1'b0;
        end else if (accept) begin
            staging_r[count_r] <= bit_in;
            par_r              <= par_fold(par_r, bit_in);
            if (count_r != CNT_LAST) begin
                count_r <= count_r + CNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end else begin
            staging_r <= staging_r;
            count_r   <= count_r;
            par_r     <= par_r;
        end
    end

    assign staging = staging_r;
    assign last    = (count_r == CNT_LAST);
    assign par_ok  = ~par_r;

endmodule

// File: rtl/cfg_frame_loader.sv
// Serial config loader: assembles a parity-protected frame and commits it atomically
// to the roof / in1or2roof configuration buses.
module cfg_frame_loader
    import cfg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic              cfg_bit,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [ROOF_W-1:0] roof,
    output logic [SEL_W-1:0]  in1or2roof,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic              busy
);

    cfg_state_e         state_r;
    logic               cfg_ready_r;
    logic               busy_r;
    logic               cfg_done_r;
    logic               cfg_err_r;
    logic [ROOF_W-1:0]  roof_r;
    logic [SEL_W-1:0]   sel_r;

    logic               clear_s;
    logic               accept_s;
    logic [FRAME_W-1:0] staging_s;
    logic               last_s;
    logic               par_ok_s;
    logic               par_bit_unused_s;

    // Parity bit itself is only consumed through the running parity.
    assign par_bit_unused_s = staging_s[PAR_BIT];

    // A restart in SHIFT wins over any bit offered in the same cycle.
    always_comb begin
        clear_s  = 1'b0;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                clear_s = cfg_start;
            end
            SHIFT: begin
                clear_s  = cfg_start;
                accept_s = cfg_valid & cfg_ready_r & ~cfg_start;
            end
            CHECK: begin
                clear_s  = 1'b0;
                accept_s = 1'b0;
            end
            default: begin
                clear_s  = 1'b0;
                accept_s = 1'b0;
            end
        endcase
    end

    cfg_shift_stage u_shift (
        .clk     (clk),
        .rst_n   (reset),
        .clear   (clear_s),
        .accept  (accept_s),
        .bit_in  (cfg_bit),
        .staging (staging_s),
        .last    (last_s),
        .par_ok  (par_ok_s)
    );

    // Frame FSM with registered handshake, status and commit outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cfg_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            cfg_done_r  <= 1'b0;
            cfg_err_r   <= 1'b0;
            roof_r      <= '0;
            sel_r       <= '0;
        end else begin
            cfg_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cfg_start) begin
                        state_r     <= SHIFT;
                        cfg_ready_r <= 1'b1;
                        busy_r      <= 1'b1;
                        cfg_err_r   <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (accept_s && last_s) begin
                        state_r     <= CHECK;
                        cfg_ready_r <= 1'b0;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                CHECK: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    if (par_ok_s) begin
                        roof_r     <= staging_s[ROOF_LSB +: ROOF_W];
                        sel_r      <= staging_s[SEL_LSB +: SEL_W];
                        cfg_done_r <= 1'b1;
                    end else begin
                        cfg_err_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cfg_ready_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready  = cfg_ready_r;
    assign busy       = busy_r;
    assign cfg_done   = cfg_done_r;
    assign cfg_err    = cfg_err_r;
    assign roof       = roof_r;
    assign in1or2roof = sel_r;

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Scenario bench for cfg_frame_loader; commits are checked against a scoreboard queue.
module tb_cfg_frame_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_start = 1'b0;
    logic        cfg_bit = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [24:0] roof;
    logic [9:0]  in1or2roof;
    logic        cfg_done;
    logic        cfg_err;
    logic        busy;

    typedef struct packed {
        logic [24:0] r;
        logic [9:0]  s;
    } commit_t;

    commit_t sb_q[$];
    commit_t mon_exp;
    int total = 0;
    int bad = 0;

    cfg_frame_loader dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_start  (cfg_start),
        .cfg_bit    (cfg_bit),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .roof       (roof),
        .in1or2roof (in1or2roof),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] mk(input logic [24:0] r, input logic [9:0] s, input logic p);
        return {p, s, r};
    endfunction

    // Scoreboard: every cfg_done pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (reset && cfg_done) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_commit roof=%h sel=%h required=no commit", roof, in1or2roof);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({roof, in1or2roof} !== {mon_exp.r, mon_exp.s}) begin
                    bad++;
                    $display("FAIL sb_commit roof=%h sel=%h required roof=%h sel=%h",
                             roof, in1or2roof, mon_exp.r, mon_exp.s);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    // Offer bits LSB first; invalid cycles carry the inverted bit as garbage.
    task automatic send_bits(input logic [35:0] f, input int n, input int pct);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 400) begin
            @(negedge clk);
            cfg_valid = ($urandom_range(0, 99) < pct);
            cfg_bit   = cfg_valid ? f[i] : ~f[i];
            if (cfg_valid && cfg_ready) i++;
            guard++;
        end
        total++;
        if (i != n) begin
            bad++;
            $display("FAIL send_timeout accepted=%0d required=%0d", i, n);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({roof, in1or2roof, cfg_done, cfg_err, cfg_ready, busy} !== 39'd0) begin
            bad++;
            $display("FAIL reset_state got=%h required=0",
                     {roof, in1or2roof, cfg_done, cfg_err, cfg_ready, busy});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        pulse_start();
        total++;
        if (busy !== 1'b1 || cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL good_shift_entry busy=%b ready=%b required=1 1", busy, cfg_ready);
        end
        sb_q.push_back('{r: 25'h0100001, s: 10'h010});
        send_bits(mk(25'h0100001, 10'h010, 1'b1), 36, 100);
        total++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0 || cfg_done !== 1'b0 || roof !== 25'h0) begin
            bad++;
            $display("FAIL good_check_cycle busy=%b ready=%b done=%b roof=%h required=1 0 0 0",
                     busy, cfg_ready, cfg_done, roof);
        end
        @(negedge clk);
        total++;
        if (cfg_done !== 1'b1 || roof !== 25'h0100001 || in1or2roof !== 10'h010 || cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL good_commit done=%b roof=%h sel=%h err=%b required=1 0100001 010 0",
                     cfg_done, roof, in1or2roof, cfg_err);
        end
        @(negedge clk);
        total++;
        if (cfg_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL good_done_width done=%b busy=%b required=0 0", cfg_done, busy);
        end
    endtask

    task automatic test_bad_parity();
        pulse_start();
        send_bits(mk(25'h0100001, 10'h010, 1'b0), 36, 100);
        @(negedge clk);
        total++;
        if (cfg_err !== 1'b1 || cfg_done !== 1'b0 || roof !== 25'h0100001 || in1or2roof !== 10'h010) begin
            bad++;
            $display("FAIL bad_parity err=%b done=%b roof=%h sel=%h required=1 0 0100001 010",
                     cfg_err, cfg_done, roof, in1or2roof);
        end
        repeat (3) @(negedge clk);
        total++;
        if (cfg_err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky err=%b required=1", cfg_err);
        end
        pulse_start();
        total++;
        if (cfg_err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL err_clear err=%b busy=%b required=0 1", cfg_err, busy);
        end
    endtask

    task automatic test_abort_restart();
        pulse_start();
        send_bits(mk(25'h0, 10'h0, 1'b0), 10, 100);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_stays_shift busy=%b ready=%b required=1 1", busy, cfg_ready);
        end
        sb_q.push_back('{r: 25'h1FFFFFF, s: 10'h3FF});
        send_bits(mk(25'h1FFFFFF, 10'h3FF, 1'b1), 36, 100);
        @(negedge clk);
        total++;
        if (roof !== 25'h1FFFFFF || in1or2roof !== 10'h3FF || cfg_done !== 1'b1) begin
            bad++;
            $display("FAIL abort_commit roof=%h sel=%h done=%b required=1ffffff 3ff 1",
                     roof, in1or2roof, cfg_done);
        end
    endtask

    task automatic test_stall();
        pulse_start();
        sb_q.push_back('{r: 25'h0100001, s: 10'h010});
        send_bits(mk(25'h0100001, 10'h010, 1'b1), 36, 50);
        @(negedge clk);
        total++;
        if (roof !== 25'h0100001 || in1or2roof !== 10'h010 || cfg_done !== 1'b1 || cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL stall_commit roof=%h sel=%h done=%b err=%b required=0100001 010 1 0",
                     roof, in1or2roof, cfg_done, cfg_err);
        end
    endtask

    task automatic test_start_in_check_and_idle_bit();
        pulse_start();
        sb_q.push_back('{r: 25'h0000003, s: 10'h000});
        send_bits(mk(25'h0000003, 10'h000, 1'b0), 36, 100);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        total++;
        if (busy !== 1'b0 || cfg_ready !== 1'b0 || cfg_done !== 1'b1 || roof !== 25'h0000003) begin
            bad++;
            $display("FAIL start_in_check busy=%b ready=%b done=%b roof=%h required=0 0 1 0000003",
                     busy, cfg_ready, cfg_done, roof);
        end
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        total++;
        if (busy !== 1'b0 || cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_check busy=%b ready=%b required=0 0", busy, cfg_ready);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || roof !== 25'h0000003 || in1or2roof !== 10'h000) begin
            bad++;
            $display("FAIL idle_bit_ignored busy=%b roof=%h sel=%h required=0 0000003 000",
                     busy, roof, in1or2roof);
        end
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL start_with_valid busy=%b ready=%b required=1 1", busy, cfg_ready);
        end
        sb_q.push_back('{r: 25'h0000001, s: 10'h200});
        send_bits(mk(25'h0000001, 10'h200, 1'b0), 36, 100);
        @(negedge clk);
        total++;
        if (roof !== 25'h0000001 || in1or2roof !== 10'h200) begin
            bad++;
            $display("FAIL start_valid_commit roof=%h sel=%h required=0000001 200", roof, in1or2roof);
        end
    endtask

    task automatic test_mid_reset();
        pulse_start();
        send_bits(mk(25'h1FFFFFF, 10'h3FF, 1'b1), 10, 100);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({roof, in1or2roof, cfg_done, cfg_err, cfg_ready, busy} !== 39'd0) begin
            bad++;
            $display("FAIL mid_reset got=%h required=0",
                     {roof, in1or2roof, cfg_done, cfg_err, cfg_ready, busy});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle busy=%b ready=%b required=0 0", busy, cfg_ready);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_abort_restart();
        test_stall();
        test_start_in_check_and_idle_bit();
        test_mid_reset();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover pending=%0d required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
